trig_stretch_arb: RTL and testbench
===================================

TRIG_STRETCH_ARB -- requirements
Module: trig_stretch_arb

Interface
REQ-001 Parameter NREQ, default 4, number of trigger requesters (2..8).
REQ-002 Parameter LEN_W, default 4, width of the stretch and holdoff length fields.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 enable  input  1  high = new grants allowed.
REQ-006 req  input  NREQ  per-requester trigger pulse; a 1 in any cycle requests one strobe.
REQ-007 stretch_len  input  LEN_W  strobe high length in cycles; 0 treated as 1.
REQ-008 holdoff_len  input  LEN_W  minimum extra low cycles after each strobe.
REQ-009 strobe  output  1  shared stretched strobe line, registered.
REQ-010 grant  output  NREQ  one-hot owner of the current strobe; zero when strobe is low.
REQ-011 ack  output  NREQ  one-cycle pulse to the served requester after its strobe ends.
REQ-012 pending  output  NREQ  latched, not-yet-served requests.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, STRETCH and HOLDOFF.
REQ-015 req[i]=1 in cycle c SHALL set pending[i] in cycle c+1; pending[i] stays set until granted.
REQ-016 Multiple pulses on req[i] before service SHALL merge into one pending request.
REQ-017 In IDLE with enable=1 and pending!=0, the block SHALL grant the first set pending bit searching upward from (last_served+1) mod NREQ, wrapping around.
REQ-018 On the grant edge the block SHALL: enter STRETCH; set grant one-hot; clear pending[i]; store i as last_served; load the counter with L=max(stretch_len,1).
REQ-019 strobe SHALL be 1 for exactly L cycles; for req in cycle c from IDLE, strobe is high in cycles c+2..c+1+L.
REQ-020 stretch_len and holdoff_len SHALL be sampled only on the grant edge; later changes do not affect the pulse in progress.
REQ-021 ack[i] SHALL pulse for one cycle in the first cycle after the last strobe cycle (c+2+L).
REQ-022 After STRETCH, the FSM SHALL enter HOLDOFF for H=holdoff_len cycles, or IDLE directly if H=0.
REQ-023 After HOLDOFF the FSM SHALL enter IDLE, so consecutive strobes are separated by at least H+1 low cycles.
REQ-024 If req[i] is high in the same cycle pending[i] is cleared by a grant, set SHALL win and pending[i] stays 1.
REQ-025 enable=0 SHALL block new grants only; a strobe or holdoff in progress completes normally and pending requests are retained.
REQ-026 Requests arriving during STRETCH or HOLDOFF SHALL be latched and served in later IDLE cycles per REQ-017.

Reset
REQ-027 With rst=1 at a clock edge: state becomes IDLE; strobe, grant, ack, pending and busy become 0; counter becomes 0; last_served becomes NREQ-1 (requester 0 has first priority).
REQ-028 rst=1 mid-strobe SHALL drop strobe on the next edge, emit no ack, and discard all pending requests.

Structure
REQ-029 The FSM state encoding and the REQ-027 reset value of last_served SHALL live in a shared package, trig_pkg.
REQ-030 The round-robin search SHALL be a combinational sub-module, rr_pick (inputs: pending, last_served; outputs: valid, index).
REQ-031 The counter width SHALL be LEN_W; no arithmetic wider than LEN_W+1 bits is required.

Verification
REQ-032 The bench SHALL cover this scenario: stretch_len=5, holdoff_len=2, req=0001 in cycle 10 -> strobe high cycles 12-16, grant=0001, ack=0001 in cycle 17, busy low from cycle 19.
REQ-033 The bench SHALL cover this scenario: req=1111 in one cycle, L=1, H=0 -> grants in order 0,1,2,3, each followed by one low cycle, and each ack once.
REQ-034 The bench SHALL cover this scenario: stretch_len=0 -> strobe exactly 1 cycle wide; stretch_len changed from 3 to 9 mid-pulse -> pulse stays 3 cycles.
REQ-035 The bench SHALL cover this scenario: req[2] re-pulsed in its own grant cycle -> pending[2]=1 after the grant, and a second strobe for requester 2 follows.
REQ-036 The bench SHALL cover this scenario: enable dropped mid-strobe with pending=0100 -> current strobe completes, no new grant until enable=1, then requester 2 is granted.
REQ-037 The bench SHALL cover this scenario: rst=1 in the 2nd strobe cycle -> strobe=0 next cycle, no ack, pending=0, next grant goes to requester 0.

Source files
------------

// File: rtl/trig_pkg.sv
// Shared definitions for the trigger stretch arbiter: FSM encoding and
// the round-robin pointer value applied at reset.
package trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  // Pointer starts on the last requester so requester 0 wins the first search.
  function automatic int unsigned last_served_rst(input int unsigned nreq);
    return nreq - 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set pending bit strictly after
// last_served, wrapping around.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  pending,
  input  logic [IDX_W-1:0] last_served,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W-1:0] cand_s;

  // Scan from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    valid  = 1'b0;
    index  = '0;
    cand_s = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand_s = IDX_W'((int'(last_served) + k) % NREQ);
      valid  = valid | pending[cand_s];
      index  = pending[cand_s] ? cand_s : index;
    end
  end

endmodule

// File: rtl/trig_stretch_arb.sv
// Round-robin arbiter driving one shared stretched strobe line, with a
// programmable holdoff gap and a per-requester completion ack.
module trig_stretch_arb
  import trig_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [NREQ-1:0]  req,
  input  logic [LEN_W-1:0] stretch_len,
  input  logic [LEN_W-1:0] holdoff_len,
  output logic             strobe,
  output logic [NREQ-1:0]  grant,
  output logic [NREQ-1:0]  ack,
  output logic [NREQ-1:0]  pending,
  output logic             busy
);

  localparam int IDX_W = $clog2(NREQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(last_served_rst(NREQ));

  state_t           state_r;
  logic [LEN_W-1:0] cnt_r;
  logic [LEN_W-1:0] hold_r;
  logic [IDX_W-1:0] last_r;
  logic             strobe_r;
  logic             busy_r;
  logic [NREQ-1:0]  grant_r;
  logic [NREQ-1:0]  ack_r;
  logic [NREQ-1:0]  pending_r;

  logic             pick_valid_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             fire_s;
  logic [NREQ-1:0]  onehot_s;
  logic [NREQ-1:0]  clr_s;
  logic [LEN_W-1:0] len_s;

  rr_pick #(
    .NREQ (NREQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .pending    (pending_r),
    .last_served(last_r),
    .valid      (pick_valid_s),
    .index      (pick_idx_s)
  );

  // Grant decision and the values captured on the grant edge.
  always_comb begin
    fire_s   = (state_r == ST_IDLE) && enable && pick_valid_s;
    onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
    clr_s    = fire_s ? onehot_s : {NREQ{1'b0}};
    len_s    = (stretch_len == {LEN_W{1'b0}}) ? LEN_W'(1'b1) : stretch_len;
  end

  // Request latching plus the IDLE/STRETCH/HOLDOFF sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      hold_r    <= '0;
      last_r    <= LAST_RST;
      strobe_r  <= 1'b0;
      busy_r    <= 1'b0;
      grant_r   <= '0;
      ack_r     <= '0;
      pending_r <= '0;
    end else begin
      ack_r     <= '0;
      pending_r <= (pending_r & ~clr_s) | req;
      case (state_r)
        ST_IDLE: begin
          if (fire_s) begin
            state_r  <= ST_STRETCH;
            strobe_r <= 1'b1;
            busy_r   <= 1'b1;
            grant_r  <= onehot_s;
            last_r   <= pick_idx_s;
            cnt_r    <= len_s;
            hold_r   <= holdoff_len;
          end else begin
            strobe_r <= 1'b0;
            busy_r   <= 1'b0;
            grant_r  <= '0;
          end
        end
        ST_STRETCH: begin
          if (cnt_r <= LEN_W'(1'b1)) begin
            strobe_r <= 1'b0;
            grant_r  <= '0;
            ack_r    <= grant_r;
            if (hold_r == {LEN_W{1'b0}}) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
              cnt_r   <= '0;
            end else begin
              state_r <= ST_HOLDOFF;
              cnt_r   <= hold_r;
            end
          end else begin
            cnt_r <= cnt_r - LEN_W'(1'b1);
          end
        end
        ST_HOLDOFF: begin
          if (cnt_r <= LEN_W'(1'b1)) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r - LEN_W'(1'b1);
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          strobe_r <= 1'b0;
          busy_r   <= 1'b0;
          grant_r  <= '0;
          cnt_r    <= '0;
        end
      endcase
    end
  end

  assign strobe  = strobe_r;
  assign grant   = grant_r;
  assign ack     = ack_r;
  assign pending = pending_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_trig_stretch_arb.sv
// Self-checking bench: directed scenarios with literal expectations, then
// random traffic checked every cycle against a schedule-based model.
module tb_trig_stretch_arb;

  localparam int NREQ  = 4;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [NREQ-1:0]  req = '0;
  logic [LEN_W-1:0] stretch_len = '0;
  logic [LEN_W-1:0] holdoff_len = '0;
  logic             strobe;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  ack;
  logic [NREQ-1:0]  pending;
  logic             busy;

  trig_stretch_arb #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req),
    .stretch_len(stretch_len), .holdoff_len(holdoff_len),
    .strobe(strobe), .grant(grant), .ack(ack), .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: a grant at the edge opening cycle g occupies strobe g..g+L-1,
  // acks at g+L and frees the arbiter at g+L+H.
  int cyc_m = 0;
  int free_m = 0;
  int s_start = -1;
  int s_end = -1;
  int ack_at = -1;
  int owner_m = 0;
  int last_m = NREQ - 1;
  logic [NREQ-1:0] pend_m = '0;
  logic            exp_strobe = 1'b0;
  logic            exp_busy = 1'b0;
  logic [NREQ-1:0] exp_grant = '0;
  logic [NREQ-1:0] exp_ack = '0;

  task automatic model_step();
    int j;
    bit found;
    cyc_m = cyc_m + 1;
    if (rst) begin
      pend_m = '0; last_m = NREQ - 1; free_m = cyc_m;
      s_start = -1; s_end = -1; ack_at = -1;
    end else begin
      logic [NREQ-1:0] clr;
      clr = '0;
      if ((cyc_m - 1) >= free_m && enable && pend_m != '0) begin
        found = 1'b0;
        for (int d = 1; d <= NREQ; d++) begin
          j = (last_m + d) % NREQ;
          if (!found && pend_m[j]) begin
            found = 1'b1;
            owner_m = j;
          end
        end
        s_start = cyc_m;
        s_end   = cyc_m + ((stretch_len == 0) ? 1 : int'(stretch_len)) - 1;
        ack_at  = s_end + 1;
        free_m  = ack_at + int'(holdoff_len);
        last_m  = owner_m;
        clr     = NREQ'(1 << owner_m);
      end
      pend_m = (pend_m & ~clr) | req;
    end
    exp_strobe = (cyc_m >= s_start) && (cyc_m <= s_end);
    exp_grant  = exp_strobe ? NREQ'(1 << owner_m) : '0;
    exp_ack    = (cyc_m == ack_at) ? NREQ'(1 << owner_m) : '0;
    exp_busy   = cyc_m < free_m;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_m);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((busy || strobe || pending != '0) && n < 300) begin
      tick();
      n++;
    end
    chk("quiet_timeout", 8'(n >= 300), 8'd0);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("m_strobe", 8'(strobe), 8'(exp_strobe));
      chk("m_grant", 8'(grant), 8'(exp_grant));
      chk("m_ack", 8'(ack), 8'(exp_ack));
      chk("m_pending", 8'(pending), 8'(pend_m));
      chk("m_busy", 8'(busy), 8'(exp_busy));
    end
  end

  initial begin
    tick();
    cmp_en = 1'b1;
    chk("rst_strobe", 8'(strobe), 8'd0);
    chk("rst_pending", 8'(pending), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_grant", 8'(grant), 8'd0);
    chk("rst_ack", 8'(ack), 8'd0);

    // Basic stretch 5, holdoff 2
    rst = 1'b0; enable = 1'b1; stretch_len = 4'd5; holdoff_len = 4'd2;
    tick();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    chk("s1_pend", 8'(pending), 8'h01);
    chk("s1_pre", 8'(strobe), 8'd0);
    for (int k = 2; k <= 9; k++) begin
      tick();
      chk("s1_strobe", 8'(strobe), 8'(k >= 2 && k <= 6));
      chk("s1_grant", 8'(grant), (k >= 2 && k <= 6) ? 8'h01 : 8'h00);
      chk("s1_ack", 8'(ack), (k == 7) ? 8'h01 : 8'h00);
      chk("s1_busy", 8'(busy), 8'(k <= 8));
    end

    // All four at once, L=1 H=0, fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0; stretch_len = 4'd1; holdoff_len = 4'd0; req = 4'b1111;
    tick();
    req = 4'b0000;
    chk("s2_pend", 8'(pending), 8'h0f);
    for (int k = 2; k <= 9; k++) begin
      tick();
      chk("s2_grant", 8'(grant), (k % 2 == 0) ? 8'(1 << ((k - 2) / 2)) : 8'h00);
      chk("s2_ack", 8'(ack), (k % 2 == 1) ? 8'(1 << ((k - 3) / 2)) : 8'h00);
    end

    // Zero stretch length, then a mid-pulse length change
    wait_quiet();
    stretch_len = 4'd0; req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    chk("s3_one_hi", 8'(strobe), 8'd1);
    tick();
    chk("s3_one_lo", 8'(strobe), 8'd0);
    chk("s3_one_ack", 8'(ack), 8'h02);
    wait_quiet();
    stretch_len = 4'd3; req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    chk("s3_hi0", 8'(strobe), 8'd1);
    stretch_len = 4'd9;
    tick();
    chk("s3_hi1", 8'(strobe), 8'd1);
    tick();
    chk("s3_hi2", 8'(strobe), 8'd1);
    tick();
    chk("s3_lo", 8'(strobe), 8'd0);
    chk("s3_ack", 8'(ack), 8'h04);

    // Re-pulse in the grant cycle wins over the clear
    wait_quiet();
    stretch_len = 4'd1; holdoff_len = 4'd0; req = 4'b0100;
    tick();
    tick();
    req = 4'b0000;
    chk("s4_grant", 8'(grant), 8'h04);
    chk("s4_pend", 8'(pending), 8'h04);
    tick();
    chk("s4_ack", 8'(ack), 8'h04);
    tick();
    chk("s4_grant2", 8'(grant), 8'h04);
    chk("s4_pend2", 8'(pending), 8'h00);
    tick();
    chk("s4_ack2", 8'(ack), 8'h04);

    // Enable dropped mid-strobe
    wait_quiet();
    stretch_len = 4'd3; req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0100; enable = 1'b0;
    tick();
    req = 4'b0000;
    chk("s5_strobe", 8'(strobe), 8'd1);
    chk("s5_pend", 8'(pending), 8'h04);
    tick();
    tick();
    chk("s5_ack", 8'(ack), 8'h01);
    for (int k = 6; k <= 9; k++) begin
      tick();
      chk("s5_hold", 8'(grant), 8'h00);
      chk("s5_pend_kept", 8'(pending), 8'h04);
    end
    enable = 1'b1;
    tick();
    chk("s5_grant", 8'(grant), 8'h04);

    // Reset in the second strobe cycle
    wait_quiet();
    stretch_len = 4'd4; holdoff_len = 4'd1; req = 4'b0010;
    tick();
    req = 4'b1000;
    tick();
    req = 4'b0000;
    chk("s6_grant", 8'(grant), 8'h02);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_strobe", 8'(strobe), 8'd0);
    chk("s6_pend", 8'(pending), 8'h00);
    chk("s6_busy", 8'(busy), 8'd0);
    for (int k = 5; k <= 8; k++) begin
      tick();
      chk("s6_noack", 8'(ack), 8'h00);
    end
    req = 4'b1001;
    tick();
    req = 4'b0000;
    tick();
    chk("s6_next", 8'(grant), 8'h01);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      tick();
      req         = ($urandom_range(0, 5) == 0) ? NREQ'($urandom) : '0;
      enable      = ($urandom_range(0, 9) != 0);
      stretch_len = LEN_W'($urandom_range(0, 6));
      holdoff_len = LEN_W'($urandom_range(0, 4));
      rst         = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0; req = '0; enable = 1'b1;
    repeat (30) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
